// File: rtl/intc_wb_if.sv
// Wishbone slave bus bundle for the interrupt controller: CPU side is master, intc_wb is slave.
interface intc_wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [1:0]  adr;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;

   modport master (
      output cyc, stb, we, adr, sel, dat_w,
      input  dat_r, ack
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_w,
      output dat_r, ack
   );
endinterface

// File: rtl/intc_wb.sv
// Wishbone-mapped interrupt controller: per-source level/edge latch, mask and fixed priority,
// with a registered vector code and request flag to the CPU.
module intc_wb #(
   parameter int unsigned NSRC     = 8,
   parameter int unsigned VECW     = 4,
   parameter int unsigned VEC_BASE = 2,
   parameter int unsigned NMI_VEC  = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   intc_wb_if.slave        bus,
   input  logic [NSRC-1:0] irq_i,
   input  logic            nmi_i,
   input  logic            int_en_i,
   output logic [VECW-1:0] inter_o,
   output logic            irq_o
);

   // Registers are kept 32 bits wide; bits at or above NSRC are held at zero by this mask.
   localparam logic [31:0] SrcMask = 32'((64'd1 << NSRC) - 64'd1);

   typedef enum logic [1:0] {StIdle, StAck, StWait} bus_st_e;

   bus_st_e         st_q, st_d;
   logic [31:0]     pend_q, pend_d;
   logic [31:0]     en_q, en_d;
   logic [31:0]     mode_q, mode_d;
   logic [31:0]     prev_q;
   logic [31:0]     dat_q, dat_d;
   logic [VECW-1:0] inter_q, inter_d;
   logic            irq_q, irq_d;

   logic        req;
   logic        wr;
   logic [31:0] be_mask;
   logic [31:0] wbits;
   logic [31:0] clr;
   logic [31:0] irq_w;
   logic [31:0] rise;
   logic [31:0] masked;
   logic [31:0] rd_data;

   assign req     = bus.cyc & bus.stb;
   assign wr      = (st_q == StAck) & req & bus.we;
   assign be_mask = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
   assign wbits   = bus.dat_w & be_mask & SrcMask;
   assign irq_w   = 32'(irq_i);
   assign rise    = irq_w & ~prev_q;
   assign masked  = pend_q & en_q;

   // One ack per strobe: after acking, wait for cyc&stb to drop before accepting again.
   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle:  if (req) st_d = StAck;
         StAck:   st_d = req ? StWait : StIdle;
         StWait:  if (!req) st_d = StIdle;
         default: st_d = StIdle;
      endcase
   end

   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      clr    = '0;
      if (wr) begin
         unique case (bus.adr)
            2'd0:    clr    = wbits;
            2'd1:    en_d   = (en_q & ~be_mask) | wbits;
            2'd2:    mode_d = (mode_q & ~be_mask) | wbits;
            default: ;
         endcase
      end
      // Edge bits: a new edge beats a same-cycle clear. Level bits simply follow irq_i.
      pend_d = ((mode_q & (rise | (pend_q & ~clr))) | (~mode_q & irq_w)) & SrcMask;
   end

   always_comb begin
      irq_d   = (|masked) | nmi_i;
      inter_d = '0;
      if (int_en_i) begin
         if (nmi_i) begin
            inter_d = VECW'(NMI_VEC);
         end else begin
            for (int i = 0; i < int'(NSRC); i++) begin
               if (masked[i]) inter_d = VECW'(VEC_BASE + i);
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      unique case (bus.adr)
         2'd0: rd_data = pend_q;
         2'd1: rd_data = en_q;
         2'd2: rd_data = mode_q;
         2'd3: begin
            rd_data[31]       = irq_q;
            rd_data[30]       = nmi_i;
            rd_data[29]       = int_en_i;
            rd_data[VECW-1:0] = inter_q;
         end
         default: ;
      endcase
      dat_d = (st_d == StAck) ? rd_data : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q    <= StIdle;
         pend_q  <= '0;
         en_q    <= '0;
         mode_q  <= '0;
         prev_q  <= '0;
         dat_q   <= '0;
         inter_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         pend_q  <= pend_d;
         en_q    <= en_d;
         mode_q  <= mode_d;
         prev_q  <= irq_w;
         dat_q   <= dat_d;
         inter_q <= inter_d;
         irq_q   <= irq_d;
      end
   end

   assign bus.ack   = (st_q == StAck);
   assign bus.dat_r = dat_q;
   assign inter_o   = inter_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_intc_wb.sv
// Directed, table-driven bench for intc_wb with default parameters (NSRC=8, VEC_BASE=2, NMI_VEC=1).
module tb_intc_wb;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq;
   logic       nmi;
   logic       int_en;
   logic [3:0] inter;
   logic       irq_out;

   intc_wb_if bus ();

   intc_wb dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .bus      (bus),
      .irq_i    (irq),
      .nmi_i    (nmi),
      .int_en_i (int_en),
      .inter_o  (inter),
      .irq_o    (irq_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] irq;
      logic       nmi;
      logic       en;
      logic [3:0] inter;
      logic       irqo;
   } vec_t;

   vec_t tbl[9];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Full access: strobe, wait for ack (bounded), hold through the ack cycle, then drop.
   task automatic xfer(input logic w, input logic [1:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] r);
      logic got;
      got = 1'b0;
      r   = '0;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.adr = a; bus.sel = s; bus.dat_w = d;
      for (int i = 0; i < 8 && !got; i++) begin
         tick(1);
         if (bus.ack) begin
            got = 1'b1;
            r   = bus.dat_r;
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      tick(1);
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      tick(1);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(1'b1, a, 4'hF, d, dummy);
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      xfer(1'b0, a, 4'hF, 32'h0, r);
      check(nm, r, exp);
   endtask

   initial begin
      int acks;
      tbl[0] = '{8'h05, 1'b0, 1'b1, 4'd4, 1'b1};
      tbl[1] = '{8'h01, 1'b0, 1'b1, 4'd2, 1'b1};
      tbl[2] = '{8'h00, 1'b0, 1'b1, 4'd0, 1'b0};
      tbl[3] = '{8'hFF, 1'b1, 1'b1, 4'd1, 1'b1};
      tbl[4] = '{8'hFF, 1'b1, 1'b0, 4'd0, 1'b1};
      tbl[5] = '{8'h80, 1'b0, 1'b1, 4'd9, 1'b1};
      tbl[6] = '{8'h80, 1'b0, 1'b0, 4'd0, 1'b1};
      tbl[7] = '{8'h00, 1'b1, 1'b1, 4'd1, 1'b1};
      tbl[8] = '{8'h42, 1'b0, 1'b1, 4'd8, 1'b1};

      rst = 1'b1; irq = '0; nmi = 1'b0; int_en = 1'b0;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.sel = '0; bus.dat_w = '0;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_inter", 32'(inter), 32'd0);
      check("rst_irq_o", 32'(irq_out), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_dat", bus.dat_r, 32'd0);
      rd_chk("rst_pend", 2'd0, 32'h0);
      rd_chk("rst_enable", 2'd1, 32'h0);
      rd_chk("rst_mode", 2'd2, 32'h0);
      rd_chk("rst_status", 2'd3, 32'h0);

      // Level-mode priority table
      wr_reg(2'd1, 32'hFF);
      wr_reg(2'd2, 32'h00);
      for (int i = 0; i < 9; i++) begin
         irq = tbl[i].irq; nmi = tbl[i].nmi; int_en = tbl[i].en;
         tick(2);
         check($sformatf("tbl%0d_inter", i), 32'(inter), 32'(tbl[i].inter));
         check($sformatf("tbl%0d_irq_o", i), 32'(irq_out), 32'(tbl[i].irqo));
         rd_chk($sformatf("tbl%0d_pend", i), 2'd0, 32'(tbl[i].irq));
      end

      // Edge source 7
      irq = '0; nmi = 1'b0; int_en = 1'b1;
      tick(2);
      wr_reg(2'd2, 32'h80);
      irq = 8'h80;
      tick(1);
      irq = 8'h00;
      tick(2);
      check("edge_inter", 32'(inter), 32'd9);
      rd_chk("edge_pend", 2'd0, 32'h80);
      check("edge_held", 32'(inter), 32'd9);
      wr_reg(2'd0, 32'h80);
      check("edge_clr_inter", 32'(inter), 32'd0);
      rd_chk("edge_clr_pend", 2'd0, 32'h00);

      // New edge arrives in the same cycle as the w1c: set must win
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 2'd0; bus.sel = 4'hF;
      bus.dat_w = 32'h80;
      tick(1);
      check("coll_ack", 32'(bus.ack), 32'd1);
      irq = 8'h80;
      tick(1);
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; irq = 8'h00;
      tick(2);
      rd_chk("coll_pend", 2'd0, 32'h80);
      check("coll_inter", 32'(inter), 32'd9);
      wr_reg(2'd0, 32'h80);

      // STATUS with NMI
      nmi = 1'b1;
      tick(2);
      rd_chk("status_nmi", 2'd3, 32'hE000_0001);
      nmi = 1'b0;

      // Masked level source becomes visible once enabled
      wr_reg(2'd1, 32'h00);
      wr_reg(2'd2, 32'h00);
      irq = 8'h08;
      tick(2);
      rd_chk("mask_pend", 2'd0, 32'h08);
      check("mask_inter", 32'(inter), 32'd0);
      check("mask_irq_o", 32'(irq_out), 32'd0);
      wr_reg(2'd1, 32'h08);
      check("unmask_inter", 32'(inter), 32'd5);
      check("unmask_irq_o", 32'(irq_out), 32'd1);
      irq = 8'h00;

      // Held strobe yields a single ack
      acks = 0;
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 2'd1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (bus.ack) acks++;
      end
      bus.cyc = 1'b0; bus.stb = 1'b0;
      tick(1);
      check("held_acks", 32'(acks), 32'd1);

      begin
         logic [31:0] dummy;
         xfer(1'b1, 2'd1, 4'b0001, 32'hFFFF, dummy);
      end
      rd_chk("sel_enable", 2'd1, 32'h00FF);

      // Reset in the middle of an access
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 2'd1;
      tick(1);
      check("mid_ack_pre", 32'(bus.ack), 32'd1);
      rst = 1'b1;
      tick(1);
      check("mid_ack_rst", 32'(bus.ack), 32'd0);
      check("mid_dat_rst", bus.dat_r, 32'd0);
      bus.cyc = 1'b0; bus.stb = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(1);
      rd_chk("mid_enable", 2'd1, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
